// File: rtl/ioq_dispatch_arbiter.sv
// Round-robin dispatch arbiter for in-order issue queues, with a one-cycle read-to-valid pipeline.
// Optional statistics counters are enabled by defining IOQ_ARB_STATS_EN.
module ioq_dispatch_arbiter #(
    parameter int numQueues    = 4,
    parameter int queueSelBits = 2,
    parameter int statsWidth   = 32
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [numQueues-1:0]    qEmpty_i,
    input  logic                    flush_i,
    input  logic                    ready_i,
    output logic [numQueues-1:0]    qRead_o,
    output logic                    dispValid_o,
    output logic [queueSelBits-1:0] dispSel_o,
    output logic [1:0]              state_o
`ifdef IOQ_ARB_STATS_EN
    ,
    output logic [statsWidth-1:0]   grantCount_o,
    output logic [statsWidth-1:0]   stallCount_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    // Reject configurations whose select width cannot address every queue.
    if (numQueues < 2 || numQueues > 8 || (1 << queueSelBits) < numQueues || statsWidth < 1) begin : g_badConfig
        $error("ioq_dispatch_arbiter: unsupported parameter combination");
    end

    state_t                  r_state;
    logic                    r_dispValid;
    logic [queueSelBits-1:0] r_dispSel;
    logic [queueSelBits-1:0] r_rrPtr;

    logic                    w_grantValid;
    logic [queueSelBits-1:0] w_grantIdx;
    logic [queueSelBits-1:0] w_nextPtr;
    logic                    w_canRead;
    logic                    w_issue;
    logic                    w_accept;
    logic [numQueues-1:0]    w_read;

    function automatic logic [queueSelBits-1:0] wrapIdx(input logic [queueSelBits-1:0] base,
                                                        input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= numQueues) sum = sum - numQueues;
        return queueSelBits'(sum);
    endfunction

    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        for (int i = 0; i < numQueues; i++) begin
            if (!w_grantValid && !qEmpty_i[wrapIdx(r_rrPtr, i)]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = wrapIdx(r_rrPtr, i);
            end
        end
    end

    // A read may only launch when the output slot is free or being drained this cycle.
    assign w_canRead = reset_i && !flush_i && (r_state != FLUSH) && (!r_dispValid || ready_i);
    assign w_issue   = w_canRead && w_grantValid;
    assign w_accept  = reset_i && !flush_i && r_dispValid && ready_i;
    assign w_nextPtr = (w_grantIdx == queueSelBits'(numQueues - 1)) ? '0
                                                                    : w_grantIdx + queueSelBits'(1);

    always_comb begin
        w_read = '0;
        if (w_issue) w_read[w_grantIdx] = 1'b1;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_state     <= IDLE;
            r_dispValid <= 1'b0;
            r_dispSel   <= '0;
            r_rrPtr     <= '0;
        end else if (flush_i) begin
            r_state     <= FLUSH;
            r_dispValid <= 1'b0;
        end else begin
            if (w_issue) begin
                r_dispSel <= w_grantIdx;
                r_rrPtr   <= w_nextPtr;
            end
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state     <= ACTIVE;
                        r_dispValid <= 1'b1;
                    end
                end
                ACTIVE, STALL: begin
                    if (!ready_i) begin
                        r_state <= STALL;
                    end else if (w_issue) begin
                        r_state     <= ACTIVE;
                        r_dispValid <= 1'b1;
                    end else begin
                        r_state     <= IDLE;
                        r_dispValid <= 1'b0;
                    end
                end
                FLUSH: begin
                    r_state     <= IDLE;
                    r_dispValid <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_dispValid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IOQ_ARB_STATS_EN
    logic [statsWidth-1:0] r_grantCount;
    logic [statsWidth-1:0] r_stallCount;

    // Counters wrap naturally; a reset while stalled drops the held dispatch uncounted.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_grantCount <= '0;
            r_stallCount <= '0;
        end else begin
            if (w_accept) r_grantCount <= r_grantCount + statsWidth'(1);
            if (r_state == STALL) r_stallCount <= r_stallCount + statsWidth'(1);
        end
    end

    assign grantCount_o = r_grantCount;
    assign stallCount_o = r_stallCount;
`else
    logic w_acceptUnused;
    assign w_acceptUnused = w_accept;
`endif

    assign qRead_o     = w_read;
    assign dispValid_o = r_dispValid;
    assign dispSel_o   = r_dispSel;
    assign state_o     = r_state;

endmodule

// File: tb/tb_ioq_dispatch_arbiter.sv
// Scoreboard bench for ioq_dispatch_arbiter: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares. Counter checks apply when IOQ_ARB_STATS_EN is defined.
module tb_ioq_dispatch_arbiter;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [3:0]  qEmpty_i;
    logic        flush_i;
    logic        ready_i;
    logic [3:0]  qRead_o;
    logic        dispValid_o;
    logic [1:0]  dispSel_o;
    logic [1:0]  state_o;
`ifdef IOQ_ARB_STATS_EN
    logic [31:0] grantCount_o;
    logic [31:0] stallCount_o;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string      name;
        logic [3:0] qRead;
        logic       valid;
        logic       chkSel;
        logic [1:0] sel;
        logic [1:0] state;
        int         grants;
        int         stalls;
    } exp_t;

    exp_t expQ[$];

    ioq_dispatch_arbiter #(
        .numQueues(4),
        .queueSelBits(2),
        .statsWidth(32)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .qEmpty_i(qEmpty_i),
        .flush_i(flush_i),
        .ready_i(ready_i),
        .qRead_o(qRead_o),
        .dispValid_o(dispValid_o),
        .dispSel_o(dispSel_o),
        .state_o(state_o)
`ifdef IOQ_ARB_STATS_EN
        ,
        .grantCount_o(grantCount_o),
        .stallCount_o(stallCount_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    // Drives one cycle of inputs just after the edge and records what that cycle should show.
    task automatic applyStimulus(input string name, input logic rst, input logic [3:0] qE,
                                 input logic fl, input logic rdy, input logic [3:0] eRead,
                                 input logic eValid, input logic eChkSel, input logic [1:0] eSel,
                                 input logic [1:0] eState, input int eGrants, input int eStalls);
        exp_t e;
        @(posedge clock_i);
        #1;
        reset_i  = rst;
        qEmpty_i = qE;
        flush_i  = fl;
        ready_i  = rdy;
        e.name   = name;
        e.qRead  = eRead;
        e.valid  = eValid;
        e.chkSel = eChkSel;
        e.sel    = eSel;
        e.state  = eState;
        e.grants = eGrants;
        e.stalls = eStalls;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s.%s: got %0h expected %0h", name, field, actual, expected);
        end
    endtask

    // Monitor: compares every cycle that has a pending expectation.
    always @(negedge clock_i) begin
        if (expQ.size() != 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput(e.name, "qRead", {28'd0, qRead_o}, {28'd0, e.qRead});
            checkOutput(e.name, "dispValid", {31'd0, dispValid_o}, {31'd0, e.valid});
            checkOutput(e.name, "state", {30'd0, state_o}, {30'd0, e.state});
            if (e.chkSel) checkOutput(e.name, "dispSel", {30'd0, dispSel_o}, {30'd0, e.sel});
`ifdef IOQ_ARB_STATS_EN
            checkOutput(e.name, "grantCount", grantCount_o, e.grants);
            checkOutput(e.name, "stallCount", stallCount_o, e.stalls);
`endif
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_i  = 1'b0;
        qEmpty_i = 4'b0000;
        flush_i  = 1'b0;
        ready_i  = 1'b0;

        //            name           rst qEmpty   fl rdy  qRead    vld chk sel st  gc  sc
        applyStimulus("rst1",        0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 0, 0,  0);
        applyStimulus("rst2",        0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 0, 0,  0);
        applyStimulus("rr0",         1, 4'b0000, 0, 1, 4'b0001, 0, 1, 0, 0, 0,  0);
        applyStimulus("rr1",         1, 4'b0000, 0, 1, 4'b0010, 1, 1, 0, 1, 0,  0);
        applyStimulus("rr2",         1, 4'b0000, 0, 1, 4'b0100, 1, 1, 1, 1, 1,  0);
        applyStimulus("rr3",         1, 4'b0000, 0, 1, 4'b1000, 1, 1, 2, 1, 2,  0);
        applyStimulus("rr4",         1, 4'b0000, 0, 1, 4'b0001, 1, 1, 3, 1, 3,  0);
        applyStimulus("rr5",         1, 4'b0000, 0, 1, 4'b0010, 1, 1, 0, 1, 4,  0);
        applyStimulus("rr6",         1, 4'b0000, 0, 1, 4'b0100, 1, 1, 1, 1, 5,  0);
        applyStimulus("rr7",         1, 4'b0000, 0, 1, 4'b1000, 1, 1, 2, 1, 6,  0);
        applyStimulus("toQ2",        1, 4'b1011, 0, 1, 4'b0100, 1, 1, 3, 1, 7,  0);
        applyStimulus("stall0",      1, 4'b0000, 0, 0, 4'b0000, 1, 1, 2, 1, 8,  0);
        applyStimulus("stall1",      1, 4'b0000, 0, 0, 4'b0000, 1, 1, 2, 2, 8,  0);
        applyStimulus("stall2",      1, 4'b0000, 0, 0, 4'b0000, 1, 1, 2, 2, 8,  1);
        applyStimulus("stallRel",    1, 4'b0000, 0, 1, 4'b1000, 1, 1, 2, 2, 8,  2);
        applyStimulus("postStall",   1, 4'b0000, 0, 1, 4'b0001, 1, 1, 3, 1, 9,  3);
        applyStimulus("flushReq",    1, 4'b0000, 1, 1, 4'b0000, 1, 1, 0, 1, 10, 3);
        applyStimulus("flushSt",     1, 4'b0000, 0, 1, 4'b0000, 0, 0, 0, 3, 10, 3);
        applyStimulus("flushResume", 1, 4'b0000, 0, 1, 4'b0010, 0, 0, 0, 0, 10, 3);
        applyStimulus("drainAll",    1, 4'b1111, 0, 1, 4'b0000, 1, 1, 1, 1, 10, 3);
        applyStimulus("toQ2b",       1, 4'b1011, 0, 1, 4'b0100, 0, 0, 0, 0, 11, 3);
        applyStimulus("stallB",      1, 4'b1111, 0, 0, 4'b0000, 1, 1, 2, 1, 11, 3);
        applyStimulus("rstStall",    0, 4'b1111, 0, 1, 4'b0000, 1, 1, 2, 2, 11, 3);
        applyStimulus("sparse0",     1, 4'b0111, 0, 1, 4'b1000, 0, 1, 0, 0, 0,  0);
        applyStimulus("sparse1",     1, 4'b0111, 0, 1, 4'b1000, 1, 1, 3, 1, 0,  0);
        applyStimulus("sparse2",     1, 4'b0111, 0, 1, 4'b1000, 1, 1, 3, 1, 1,  0);
        applyStimulus("drainGrant",  1, 4'b1101, 0, 1, 4'b0010, 1, 1, 3, 1, 2,  0);
        applyStimulus("drainAcc",    1, 4'b1111, 0, 1, 4'b0000, 1, 1, 1, 1, 3,  0);
        applyStimulus("drainIdle",   1, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 0, 4,  0);
        applyStimulus("flushIdle",   1, 4'b1111, 1, 0, 4'b0000, 0, 0, 0, 0, 4,  0);
        applyStimulus("flushHold",   1, 4'b0000, 1, 1, 4'b0000, 0, 0, 0, 3, 4,  0);
        applyStimulus("flushLast",   1, 4'b0000, 0, 1, 4'b0000, 0, 0, 0, 3, 4,  0);
        applyStimulus("resumePtr",   1, 4'b0000, 0, 1, 4'b0100, 0, 0, 0, 0, 4,  0);
        applyStimulus("final",       1, 4'b1111, 0, 1, 4'b0000, 1, 1, 2, 1, 4,  0);

        for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
            @(negedge clock_i);
            #1;
        end
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
